lcd_overlay_ctrl: RTL and testbench
===================================

LCD_OVERLAY_CTRL -- requirements
Module: lcd_overlay_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- CW, 8, colour bits per channel
- HACT, 800, active pixels per line
- VACT, 480, active lines per frame
- BOX_W, 64, overlay box width in pixels
- BOX_H, 64, overlay box height in lines
- STEP_S, 5, small move step in pixels
- STEP_L, 10, large move step in pixels
- XW, 11, x counter width
- YW, 10, y counter width

REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1, pixel clock
- nRESET, in, 1, synchronous active-low reset, sampled on CLK rising edge
- Hsync, in, 1, active-low line sync
- Vsync, in, 1, active-low frame sync
- DE_in, in, 1, active-pixel strobe
- R_in, in, CW, red pixel data
- G_in, in, CW, green pixel data
- B_in, in, CW, blue pixel data
- PushButton, in, 4, active-low buttons: [0] left, [1] right, [2] up, [3] down
- SW, in, 2, SW[0]: 0 = STEP_S, 1 = STEP_L; SW[1]: 1 = hold the box (moves ignored)
- MODE, in, 2, overlay mode
- R, out, CW, red pixel out
- G, out, CW, green pixel out
- B, out, CW, blue pixel out
- Hsync_out, out, 1, delayed Hsync
- Vsync_out, out, 1, delayed Vsync
- DE_out, out, 1, delayed DE_in
- Tpower, out, 1, backlight enable
- box_x, out, XW, current box left edge
- box_y, out, YW, current box top edge

Function
REQ-003 PushButton SHALL pass through a 2-flop synchroniser; a press SHALL be detected on the synchronised 1->0 edge only, giving one event per press.
REQ-004 Detected events SHALL set per-direction pending flags; the flags SHALL be consumed only at frame start, defined as the Vsync 1->0 edge.
REQ-005 At frame start, box_x SHALL be updated by +step (right only), -step (left only), or held (neither or both), with step = STEP_L if SW[0] else STEP_S; box_y SHALL be updated the same way from up/down; all pending flags SHALL then clear.
REQ-006 Box arithmetic SHALL saturate: box_x clamped to [0, HACT-BOX_W], box_y clamped to [0, VACT-BOX_H]; no wrap-around; an underflowing subtraction SHALL yield 0.
REQ-007 With SW[1]=1, events SHALL be discarded at detection and pending flags held at 0.
REQ-008 If an event arrives in the same cycle as frame start, it SHALL be applied at the next frame start, not dropped.
REQ-009 hcnt SHALL increment each cycle DE_in=1 and reset to 0 in the first cycle DE_in=0; vcnt SHALL increment on each DE_in 1->0 edge and reset to 0 at frame start. Both SHALL hold at max rather than wrap.
REQ-010 inside SHALL be (box_x <= hcnt < box_x+BOX_W) AND (box_y <= vcnt < box_y+BOX_H), evaluated with the pre-increment counters of the current pixel.
REQ-011 MODE SHALL select the pixel transform:
- 0: pass-through
- 1: zero outside the box
- 2: zero inside the box
- 3: bitwise invert inside the box
REQ-012 MODE SHALL be registered at frame start only; a mid-frame change SHALL take effect on the next frame.
REQ-013 Pipeline latency SHALL be 2 CLK for R/G/B, DE_out, Hsync_out and Vsync_out, all aligned; R/G/B SHALL be 0 whenever DE_out=0.
REQ-014 Tpower SHALL be 1 except during reset.

Reset
REQ-015 While nRESET=0 at a CLK edge:
- R, G, B SHALL be 0
- DE_out SHALL be 0; Hsync_out and Vsync_out SHALL be 1
- box_x SHALL be (HACT-BOX_W)/2 and box_y SHALL be (VACT-BOX_H)/2
- pending flags, counters and edge detectors SHALL clear; latched MODE SHALL be 0
- Tpower SHALL be 0
REQ-016 Synchroniser flops SHALL reset to 1 so that no event is generated on reset release.
REQ-017 Reset asserted mid-frame SHALL abort the frame; output restarts at the next frame start.

Verification
REQ-018 Bench SHALL cover these directed scenarios (default parameters):
- Reset, MODE=0, a 3-pixel line {R_in=0x11,0x22,0x33} -> R = 0x11,0x22,0x33 two cycles after each input, with DE_out aligned; box_x=368, box_y=208.
- SW=00, PushButton[1] pressed once, then frame start -> box_x=373 after the frame start; a second press with SW[0]=1 -> 383.
- Left pressed 80 times with SW[0]=1 -> box_x saturates at 0 with no wrap; right pressed repeatedly -> box_x saturates at 736.
- Left and right pressed in the same frame -> box_x unchanged; a press coincident with the Vsync falling edge -> applied one frame later.
- MODE=3, box at (368,208), pixel (368,208) R_in=0x0F -> R=0xF0; pixel (367,208) -> R=0x0F; MODE changed mid-frame -> no effect until the next frame.
- nRESET=0 mid-line -> R/G/B=0, DE_out=0 next edge; after release, buttons held low -> no event and box stays centred.

Source files
------------

// File: rtl/lcd_overlay_ctrl.sv
// LCD overlay controller: button-steered box with per-frame mode, applied to a
// 2-cycle RGB/sync pipeline.
module lcd_overlay_ctrl #(
  parameter int unsigned CW     = 8,
  parameter int unsigned HACT   = 800,
  parameter int unsigned VACT   = 480,
  parameter int unsigned BOX_W  = 64,
  parameter int unsigned BOX_H  = 64,
  parameter int unsigned STEP_S = 5,
  parameter int unsigned STEP_L = 10,
  parameter int unsigned XW     = 11,
  parameter int unsigned YW     = 10
) (
  input  logic          CLK,
  input  logic          nRESET,
  input  logic          Hsync,
  input  logic          Vsync,
  input  logic          DE_in,
  input  logic [CW-1:0] R_in,
  input  logic [CW-1:0] G_in,
  input  logic [CW-1:0] B_in,
  input  logic [3:0]    PushButton,
  input  logic [1:0]    SW,
  input  logic [1:0]    MODE,
  output logic [CW-1:0] R,
  output logic [CW-1:0] G,
  output logic [CW-1:0] B,
  output logic          Hsync_out,
  output logic          Vsync_out,
  output logic          DE_out,
  output logic          Tpower,
  output logic [XW-1:0] box_x,
  output logic [YW-1:0] box_y
);

  localparam int unsigned XE     = XW + 1;
  localparam int unsigned YE     = YW + 1;
  localparam int unsigned X_MAX  = HACT - BOX_W;
  localparam int unsigned Y_MAX  = VACT - BOX_H;
  localparam int unsigned X_INIT = X_MAX / 2;
  localparam int unsigned Y_INIT = Y_MAX / 2;

  logic [3:0]    btn_s1, btn_s2, btn_prev, pend;
  logic [2:0]    arm;
  logic          vs_q, de_q, run;
  logic [1:0]    mode_q;
  logic [XW-1:0] hcnt;
  logic [YW-1:0] vcnt;
  logic [CW-1:0] s1_r, s1_g, s1_b;
  logic          s1_de, s1_hs, s1_vs;

  logic          frame_start_c, inside_c, pix_en_c;
  logic [3:0]    event_c;
  logic [XE-1:0] step_x_c;
  logic [YE-1:0] step_y_c;
  logic [XW-1:0] next_x_c;
  logic [YW-1:0] next_y_c;

  function automatic logic [XW-1:0] move_x(input logic [XW-1:0] cur, input logic inc,
                                           input logic dec, input logic [XE-1:0] step);
    logic [XE-1:0] w;
    w = {1'b0, cur};
    if (inc && !dec) begin
      w = w + step;
      if (w > XE'(X_MAX)) w = XE'(X_MAX);
    end else if (dec && !inc) begin
      w = (w >= step) ? w - step : '0;
    end
    return w[XW-1:0];
  endfunction

  function automatic logic [YW-1:0] move_y(input logic [YW-1:0] cur, input logic inc,
                                           input logic dec, input logic [YE-1:0] step);
    logic [YE-1:0] w;
    w = {1'b0, cur};
    if (inc && !dec) begin
      w = w + step;
      if (w > YE'(Y_MAX)) w = YE'(Y_MAX);
    end else if (dec && !inc) begin
      w = (w >= step) ? w - step : '0;
    end
    return w[YW-1:0];
  endfunction

  function automatic logic [CW-1:0] xform(input logic [CW-1:0] v, input logic ins,
                                          input logic [1:0] m);
    logic [CW-1:0] o;
    case (m)
      2'd1:    o = ins ? v : '0;
      2'd2:    o = ins ? '0 : v;
      2'd3:    o = ins ? ~v : v;
      default: o = v;
    endcase
    return o;
  endfunction

  // Events are masked until the synchroniser has flushed its reset value.
  always_comb begin
    frame_start_c = vs_q & ~Vsync;
    event_c       = arm[2] ? (btn_prev & ~btn_s2) : 4'b0000;
    step_x_c      = SW[0] ? XE'(STEP_L) : XE'(STEP_S);
    step_y_c      = SW[0] ? YE'(STEP_L) : YE'(STEP_S);
    next_x_c      = move_x(box_x, pend[1], pend[0], step_x_c);
    next_y_c      = move_y(box_y, pend[3], pend[2], step_y_c);
    pix_en_c      = DE_in & run;
    inside_c      = ({1'b0, hcnt} >= {1'b0, box_x}) &&
                    ({1'b0, hcnt} <  ({1'b0, box_x} + XE'(BOX_W))) &&
                    ({1'b0, vcnt} >= {1'b0, box_y}) &&
                    ({1'b0, vcnt} <  ({1'b0, box_y} + YE'(BOX_H)));
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      btn_s1    <= 4'hF;
      btn_s2    <= 4'hF;
      btn_prev  <= 4'h0;
      arm       <= '0;
      pend      <= '0;
      vs_q      <= 1'b0;
      de_q      <= 1'b0;
      run       <= 1'b0;
      mode_q    <= '0;
      hcnt      <= '0;
      vcnt      <= '0;
      box_x     <= XW'(X_INIT);
      box_y     <= YW'(Y_INIT);
      s1_r      <= '0;
      s1_g      <= '0;
      s1_b      <= '0;
      s1_de     <= 1'b0;
      s1_hs     <= 1'b1;
      s1_vs     <= 1'b1;
      R         <= '0;
      G         <= '0;
      B         <= '0;
      DE_out    <= 1'b0;
      Hsync_out <= 1'b1;
      Vsync_out <= 1'b1;
      Tpower    <= 1'b0;
    end else begin
      btn_s1   <= PushButton;
      btn_s2   <= btn_s1;
      btn_prev <= btn_s2;
      arm      <= {arm[1:0], 1'b1};
      vs_q     <= Vsync;
      de_q     <= DE_in;
      Tpower   <= 1'b1;

      // Events landing on the frame-start cycle carry over to the next frame.
      if (SW[1])              pend <= '0;
      else if (frame_start_c) pend <= event_c;
      else                    pend <= pend | event_c;

      if (frame_start_c) begin
        box_x  <= next_x_c;
        box_y  <= next_y_c;
        mode_q <= MODE;
        run    <= 1'b1;
      end

      if (DE_in) begin
        if (hcnt != '1) hcnt <= hcnt + 1'b1;
      end else begin
        hcnt <= '0;
      end

      if (frame_start_c)                       vcnt <= '0;
      else if (de_q && !DE_in && vcnt != '1)   vcnt <= vcnt + 1'b1;

      s1_r      <= pix_en_c ? xform(R_in, inside_c, mode_q) : '0;
      s1_g      <= pix_en_c ? xform(G_in, inside_c, mode_q) : '0;
      s1_b      <= pix_en_c ? xform(B_in, inside_c, mode_q) : '0;
      s1_de     <= pix_en_c;
      s1_hs     <= Hsync;
      s1_vs     <= Vsync;
      R         <= s1_r;
      G         <= s1_g;
      B         <= s1_b;
      DE_out    <= s1_de;
      Hsync_out <= s1_hs;
      Vsync_out <= s1_vs;
    end
  end

endmodule

// File: tb/tb_lcd_overlay_ctrl.sv
// Bench for lcd_overlay_ctrl: directed sequences, a mode/box vector table and
// randomized frames against a frame-level reference model.
module tb_lcd_overlay_ctrl;

  localparam int XMAX = 736;
  localparam int YMAX = 416;
  localparam int XC   = 368;
  localparam int YC   = 208;

  logic       CLK = 1'b0;
  logic       nRESET, Hsync, Vsync, DE_in;
  logic [7:0] R_in, G_in, B_in, R, G, B;
  logic [3:0] PushButton;
  logic [1:0] SW, MODE;
  logic       Hsync_out, Vsync_out, DE_out, Tpower;
  logic [10:0] box_x;
  logic [9:0]  box_y;

  always #5 CLK = ~CLK;

  lcd_overlay_ctrl dut (
    .CLK(CLK), .nRESET(nRESET), .Hsync(Hsync), .Vsync(Vsync), .DE_in(DE_in),
    .R_in(R_in), .G_in(G_in), .B_in(B_in), .PushButton(PushButton), .SW(SW),
    .MODE(MODE), .R(R), .G(G), .B(B), .Hsync_out(Hsync_out), .Vsync_out(Vsync_out),
    .DE_out(DE_out), .Tpower(Tpower), .box_x(box_x), .box_y(box_y)
  );

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  typedef struct {
    int         mode;
    int         mode_mid;
    int         x;
    int         y;
    logic [7:0] rin;
    logic [7:0] rexp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: box, pending moves, latched mode, frame-valid flag.
  int       m_bx, m_by, m_mode;
  bit       m_run, m_vs_prev, m_pin_valid, e_valid, exp_tp;
  bit [3:0] m_pend, m_evq0, m_evq1, m_pin_prev;
  pix_t     e_prev, e_out;
  int       cur_x, cur_y;

  localparam pix_t RST_PIX = '{de: 1'b0, hs: 1'b1, vs: 1'b1, r: 8'h00, g: 8'h00, b: 8'h00};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] xf(input logic [7:0] v, input bit ins);
    case (m_mode)
      1:       return ins ? v : 8'h00;
      2:       return ins ? 8'h00 : v;
      3:       return ins ? ~v : v;
      default: return v;
    endcase
  endfunction

  function automatic pix_t model_pixel();
    pix_t p;
    bit   ins;
    ins  = (cur_x >= m_bx) && (cur_x < m_bx + 64) && (cur_y >= m_by) && (cur_y < m_by + 64);
    p.hs = Hsync;
    p.vs = Vsync;
    p.de = DE_in && m_run;
    p.r  = p.de ? xf(R_in, ins) : 8'h00;
    p.g  = p.de ? xf(G_in, ins) : 8'h00;
    p.b  = p.de ? xf(B_in, ins) : 8'h00;
    return p;
  endfunction

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  // One clock: evaluate the model for this edge, advance, then compare.
  task automatic cyc();
    pix_t     now;
    bit       fs;
    bit [3:0] evs;
    int       step;
    now    = model_pixel();
    exp_tp = nRESET;
    if (!nRESET) begin
      m_bx = XC; m_by = YC; m_mode = 0; m_run = 0; m_vs_prev = 0;
      m_pend = 0; m_evq0 = 0; m_evq1 = 0; m_pin_valid = 0;
      e_out = RST_PIX; e_prev = RST_PIX; e_valid = 1;
    end else begin
      e_out  = e_prev;
      e_prev = now;
      fs     = m_vs_prev && !Vsync;
      evs    = m_evq0;
      m_evq0 = m_evq1;
      m_evq1 = m_pin_valid ? (m_pin_prev & ~PushButton) : 4'h0;
      m_pin_prev  = PushButton;
      m_pin_valid = 1;
      if (fs) begin
        step = SW[0] ? 10 : 5;
        if (m_pend[1] && !m_pend[0]) m_bx = clampi(m_bx + step, XMAX);
        if (m_pend[0] && !m_pend[1]) m_bx = clampi(m_bx - step, XMAX);
        if (m_pend[3] && !m_pend[2]) m_by = clampi(m_by + step, YMAX);
        if (m_pend[2] && !m_pend[3]) m_by = clampi(m_by - step, YMAX);
        m_mode = int'(MODE);
        m_run  = 1;
      end
      if (SW[1])   m_pend = 0;
      else if (fs) m_pend = evs;
      else         m_pend = m_pend | evs;
      m_vs_prev = Vsync;
    end
    @(posedge CLK);
    #1;
    if (e_valid) begin
      check("pix", {DE_out, Hsync_out, Vsync_out, R, G, B}, e_out);
      check("box_x", 32'(box_x), 32'(m_bx));
      check("box_y", 32'(box_y), 32'(m_by));
      check("tpower", 32'(Tpower), 32'(exp_tp));
    end
  endtask

  task automatic set_idle();
    DE_in = 0; Hsync = 1; Vsync = 1; R_in = 0; G_in = 0; B_in = 0;
  endtask

  task automatic idle(input int n);
    set_idle();
    repeat (n) cyc();
  endtask

  task automatic vsync_fs();
    set_idle();
    Vsync = 0; cyc(); cyc();
    Vsync = 1; cyc();
    cur_y = 0;
  endtask

  task automatic blank_line();
    DE_in = 0; Hsync = 0; cyc();
    Hsync = 1; cyc();
    cur_y++;
  endtask

  task automatic skip_lines(input int n);
    for (int i = 0; i < n; i++) begin
      DE_in = 1; cur_x = 0; R_in = 8'($urandom); cyc();
      blank_line();
    end
  endtask

  task automatic press(input logic [3:0] m);
    set_idle();
    PushButton = ~m; repeat (3) cyc();
    PushButton = 4'hF; repeat (3) cyc();
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{3, 3, 368, 208, 8'h0F, 8'hF0};
    tbl[1]  = '{3, 3, 367, 208, 8'h0F, 8'h0F};
    tbl[2]  = '{3, 3, 431, 271, 8'h5A, 8'hA5};
    tbl[3]  = '{3, 3, 432, 208, 8'h5A, 8'h5A};
    tbl[4]  = '{3, 3, 368, 207, 8'h3C, 8'h3C};
    tbl[5]  = '{1, 1, 368, 208, 8'h33, 8'h33};
    tbl[6]  = '{1, 1, 367, 208, 8'h33, 8'h00};
    tbl[7]  = '{2, 2, 368, 208, 8'h33, 8'h00};
    tbl[8]  = '{2, 2, 368, 272, 8'h33, 8'h33};
    tbl[9]  = '{3, 0, 368, 208, 8'h0F, 8'hF0};
    tbl[10] = '{0, 0, 368, 208, 8'h0F, 8'h0F};

    e_valid = 0; cur_x = 0; cur_y = 0;
    PushButton = 4'hF; SW = 2'b00; MODE = 2'd0; nRESET = 0;
    set_idle();

    // Reset, then a 3-pixel line in pass-through mode.
    repeat (4) cyc();
    check("rst_de", 32'(DE_out), 0);
    check("rst_vs", 32'(Vsync_out), 1);
    nRESET = 1;
    idle(2);
    check("ctr_x", 32'(box_x), XC);
    check("ctr_y", 32'(box_y), YC);
    vsync_fs();
    idle(1);
    DE_in = 1; cur_x = 0; R_in = 8'h11; cyc();
    check("l3_pre_de", 32'(DE_out), 0);
    cur_x = 1; R_in = 8'h22; cyc();
    check("l3_r0", {DE_out, R}, {1'b1, 8'h11});
    cur_x = 2; R_in = 8'h33; cyc();
    check("l3_r1", {DE_out, R}, {1'b1, 8'h22});
    DE_in = 0; R_in = 0; cyc();
    check("l3_r2", {DE_out, R}, {1'b1, 8'h33});
    cyc();
    check("l3_post", {DE_out, R}, 9'h000);
    Hsync = 0; cyc(); Hsync = 1; cyc();

    // Mode / box-edge vector table, box centred.
    foreach (tbl[k]) begin
      MODE = 2'(tbl[k].mode);
      vsync_fs();
      MODE = 2'(tbl[k].mode_mid);
      skip_lines(tbl[k].y);
      for (int xx = 0; xx <= tbl[k].x; xx++) begin
        DE_in = 1; cur_x = xx; G_in = 0; B_in = 0;
        R_in = (xx == tbl[k].x) ? tbl[k].rin : 8'h00;
        cyc();
      end
      DE_in = 0; R_in = 0; cyc();
      check($sformatf("tbl%0d_r", k), {DE_out, R}, {1'b1, tbl[k].rexp});
      Hsync = 0; cyc(); Hsync = 1; cyc();
    end
    MODE = 2'd0;

    // Single presses with small then large step.
    SW = 2'b00; press(4'b0010); vsync_fs(); idle(2);
    check("right_s", 32'(box_x), 373);
    SW = 2'b01; press(4'b0010); vsync_fs(); idle(2);
    check("right_l", 32'(box_x), 383);

    // Saturation at both ends.
    repeat (80) begin press(4'b0001); vsync_fs(); end
    check("sat_lo", 32'(box_x), 0);
    repeat (80) begin press(4'b0010); vsync_fs(); end
    check("sat_hi", 32'(box_x), XMAX);
    SW = 2'b11; press(4'b0001); vsync_fs(); idle(2);
    check("hold", 32'(box_x), XMAX);

    // Opposing presses cancel; press landing on frame start slips a frame.
    SW = 2'b00; press(4'b0001); vsync_fs(); idle(2);
    check("left_s", 32'(box_x), 731);
    press(4'b0011); vsync_fs(); idle(2);
    check("lr_cancel", 32'(box_x), 731);
    set_idle(); PushButton = 4'b1110; cyc(); cyc();
    Vsync = 0; cyc(); cyc(); Vsync = 1; cyc();
    PushButton = 4'hF; idle(3);
    check("coinc_hold", 32'(box_x), 731);
    vsync_fs(); idle(2);
    check("coinc_next", 32'(box_x), 726);

    // Mid-line reset with buttons held low across release.
    vsync_fs(); idle(1);
    for (int xx = 0; xx < 3; xx++) begin DE_in = 1; cur_x = xx; R_in = 8'hAA; cyc(); end
    nRESET = 0; PushButton = 4'h0; cur_x = 3; cyc();
    check("mid_rst", {DE_out, R, G, B}, 25'h0);
    cyc(); cyc();
    nRESET = 1;
    for (int xx = 0; xx < 4; xx++) begin DE_in = 1; cur_x = xx; R_in = 8'h55; cyc(); end
    idle(10); vsync_fs(); idle(4);
    check("rst_btn_x", 32'(box_x), XC);
    check("rst_btn_y", 32'(box_y), YC);
    PushButton = 4'hF; idle(4);

    // Park box at the top-left, then randomized frames.
    SW = 2'b01;
    repeat (40) begin press(4'b0101); vsync_fs(); end
    check("park_x", 32'(box_x), 0);
    check("park_y", 32'(box_y), 0);
    for (int f = 0; f < 4; f++) begin
      SW   = 2'($urandom_range(0, 3));
      MODE = 2'($urandom_range(0, 3));
      vsync_fs();
      for (int ln = 0; ln < 70; ln++) begin
        for (int xx = 0; xx < 72; xx++) begin
          DE_in = 1; cur_x = xx;
          R_in = 8'($urandom); G_in = 8'($urandom); B_in = 8'($urandom);
          if ($urandom_range(0, 31) == 0) begin
            int b;
            b = $urandom_range(0, 3);
            PushButton[b] = ~PushButton[b];
          end
          if ($urandom_range(0, 199) == 0) MODE = 2'($urandom_range(0, 3));
          cyc();
        end
        blank_line();
      end
      PushButton = 4'hF;
      idle(4);
    end
    vsync_fs(); idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
